// File: rtl/iterative_alu.sv
// Execute-stage ALU: logic and add/sub finish in one cycle, shifts walk one
// bit position per cycle behind a start/busy/done handshake.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_operation,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Low two opcode bits of SLL/SRL/SRA select the direction directly.
    typedef enum logic [1:0] {
        SH_LEFT        = 2'd0,
        SH_RIGHT_LOGIC = 2'd1,
        SH_RIGHT_ARITH = 2'd2
    } shift_kind_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;

    state_t           state;
    state_t           next_state;
    shift_kind_t      kind;
    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] alu_value;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] step_value;

    assign shamt    = i_b[SHW-1:0];
    assign accept   = i_start && (state == IDLE || state == DONE);
    assign is_shift = (i_operation == OP_SLL) || (i_operation == OP_SRL) ||
                      (i_operation == OP_SRA);
    assign o_busy   = (state == SHIFT);
    assign o_done   = (state == DONE);

    // Single-cycle datapath for the non-shift opcodes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        alu_value = '0;
        case (i_operation)
            OP_AND:  alu_value = i_a & i_b;
            OP_OR:   alu_value = i_a | i_b;
            OP_ADD:  alu_value = i_a + i_b;
            OP_XOR:  alu_value = i_a ^ i_b;
            OP_SUB:  alu_value = i_a - i_b;
            default: alu_value = '0;
        endcase
    end

    // One-position shift of the working register in the captured direction.
    always_comb begin
        step_value = shreg;
        case (kind)
            SH_LEFT:        step_value = {shreg[WIDTH-2:0], 1'b0};
            SH_RIGHT_LOGIC: step_value = {1'b0, shreg[WIDTH-1:1]};
            SH_RIGHT_ARITH: step_value = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            default:        step_value = shreg;
        endcase
    end

    // Next-state logic; DONE re-accepts directly for back-to-back throughput.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    next_state = (is_shift && shamt != '0) ? SHIFT : DONE;
                else
                    next_state = IDLE;
            end
            SHIFT:   next_state = (count == SHW'(1)) ? DONE : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Operand capture, shift iteration and result write-back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: all datapath registers are reset so a shift aborted by
            // reset leaves no stale count or partial value behind.
            o_result <= '0;
            o_zero   <= 1'b1;
            shreg    <= '0;
            count    <= '0;
            kind     <= SH_LEFT;
        end else if (accept) begin
            if (!is_shift) begin
                o_result <= alu_value;
                o_zero   <= (alu_value == '0);
            end else if (shamt == '0) begin
                o_result <= i_a;
                o_zero   <= (i_a == '0);
            end else begin
                shreg <= i_a;
                count <= shamt;
                kind  <= shift_kind_t'(i_operation[1:0]);
            end
        end else if (state == SHIFT) begin
            shreg <= step_value;
            count <= count - SHW'(1);
            if (count == SHW'(1)) begin
                o_result <= step_value;
                o_zero   <= (step_value == '0);
            end
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_iterative_alu;

    localparam int WIDTH = 32;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [3:0]       i_operation = '0;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic [WIDTH-1:0] o_result;
    logic             o_zero;
    logic             o_busy;
    logic             o_done;

    int n_vec  = 0;
    int n_fail = 0;

    iterative_alu #(.WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_operation (i_operation),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_result    (o_result),
        .o_zero      (o_zero),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // Clock generation.
    always #5 i_clk = ~i_clk;

    // Reference: result of an opcode straight from the operation table.
    function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        int sh;
        sh = int'(b % WIDTH);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd6:    return a - b;
            4'd8:    return a << sh;
            4'd9:    return a >> sh;
            4'd10:   return $unsigned($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    // Reference: cycles spent busy before the done pulse.
    function automatic int ref_latency(input logic [3:0] op, input logic [WIDTH-1:0] b);
        if (op == 4'd8 || op == 4'd9 || op == 4'd10)
            return int'(b % WIDTH);
        return 0;
    endfunction

    // Issue one operation and follow it to completion, checking timing and result.
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp, input bit disturb);
        logic [WIDTH-1:0] prev;
        int cyc;
        int busy_cnt;
        int lat;
        bit leak;
        lat  = ref_latency(op, b);
        prev = o_result;
        @(negedge i_clk);
        i_start = 1'b1; i_operation = op; i_a = a; i_b = b;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 0; busy_cnt = 0; leak = 0;
        while (o_done !== 1'b1 && cyc < 64) begin
            if (o_busy === 1'b1) busy_cnt++;
            if (o_result !== prev) leak = 1;
            if (disturb) begin
                i_start = 1'b1; i_operation = 4'(2 * $urandom_range(0, 5));
                i_a = $urandom; i_b = $urandom;
            end
            @(negedge i_clk);
            cyc++;
        end
        i_start = 1'b0;
        n_vec++;
        if (cyc >= 64) begin
            n_fail++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
        end
        n_vec++;
        if (cyc !== lat) begin
            n_fail++; $display("FAIL %s latency: got %0d required %0d", name, cyc, lat);
        end
        n_vec++;
        if (busy_cnt !== lat) begin
            n_fail++; $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, lat);
        end
        n_vec++;
        if (leak) begin
            n_fail++; $display("FAIL %s hidden_result: o_result moved before done", name);
        end
        n_vec++;
        if (o_result !== exp) begin
            n_fail++; $display("FAIL %s result: got %h required %h", name, o_result, exp);
        end
        n_vec++;
        if (o_zero !== (exp == '0) || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s flags: zero=%b busy=%b required zero=%b busy=0",
                               name, o_zero, o_busy, exp == '0);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        n_vec++;
        if (o_result !== '0 || o_zero !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: result=%h zero=%b busy=%b done=%b required 0/1/0/0",
                     o_result, o_zero, o_busy, o_done);
        end
    endtask

    task automatic test_single_cycle();
        do_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
        do_op("sub", 4'd6, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
        do_op("and", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
        do_op("or",  4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0);
        do_op("xor", 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    endtask

    task automatic test_shift();
        do_op("sll3", 4'd8, 32'h1, 32'h23, 32'h8, 0);
        do_op("sra31", 4'd10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0);
        do_op("srl31", 4'd9, 32'h8000_0000, 32'd31, 32'h0000_0001, 0);
    endtask

    task automatic test_boundary();
        do_op("shamt0", 4'd9, 32'h1234, 32'h20, 32'h1234, 0);
        do_op("illegal", 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 0);
    endtask

    task automatic test_ignored_start();
        do_op("sll_disturbed", 4'd8, 32'h0000_00A5, 32'd12, 32'h000A_5000, 1);
        do_op("sra_disturbed", 4'd10, 32'h9000_0000, 32'd4, 32'hF900_0000, 1);
    endtask

    task automatic test_back_to_back();
        logic [3:0]       ops [3] = '{4'd2, 4'd3, 4'd6};
        logic [WIDTH-1:0] av  [3];
        logic [WIDTH-1:0] bv  [3];
        for (int i = 0; i < 3; i++) begin
            av[i] = $urandom; bv[i] = $urandom;
        end
        @(negedge i_clk);
        for (int i = 0; i < 3; i++) begin
            i_start = 1'b1; i_operation = ops[i]; i_a = av[i]; i_b = bv[i];
            @(negedge i_clk);
            n_vec++;
            if (o_done !== 1'b1 || o_result !== ref_result(ops[i], av[i], bv[i])) begin
                n_fail++;
                $display("FAIL b2b_%0d: done=%b result=%h required done=1 result=%h",
                         i, o_done, o_result, ref_result(ops[i], av[i], bv[i]));
            end
        end
        i_start = 1'b0;
        @(negedge i_clk);
        n_vec++;
        if (o_done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: done=%b required 0", o_done);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit saw_done;
        @(negedge i_clk);
        i_start = 1'b1; i_operation = 4'd8; i_a = 32'h3; i_b = 32'd20;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        saw_done = 0;
        n_vec++;
        if (o_busy !== 1'b0 || o_result !== '0 || o_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_shift: busy=%b result=%h zero=%b required 0/0/1",
                     o_busy, o_result, o_zero);
        end
        repeat (25) begin
            if (o_done === 1'b1) saw_done = 1;
            @(negedge i_clk);
        end
        n_vec++;
        if (saw_done) begin
            n_fail++; $display("FAIL reset_no_done: done pulse seen after aborted shift");
        end
    endtask

    task automatic test_random();
        logic [3:0] op_pool [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd8, 4'd9, 4'd10, 4'd5, 4'd12};
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int i = 0; i < 40; i++) begin
            op = op_pool[$urandom_range(0, 9)];
            a  = $urandom;
            b  = $urandom;
            do_op("random", op, a, b, ref_result(op, a, b), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_shift();
        test_boundary();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
